// File: rtl/rf_write_arbiter_if.sv
// Requester and register-file write-port bundle for rf_write_arbiter.
// The master side is the writeback sources; the slave side is the arbiter.
interface rf_write_arbiter_if #(
    parameter int pw   = 3,
    parameter int NREQ = 3,
    parameter int dw   = 8
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*pw-1:0] req_addr;
    logic [NREQ*dw-1:0] req_data;
    logic               wr_en;
    logic [pw-1:0]      wr_addr;
    logic [dw-1:0]      wr_data;
    logic [GW-1:0]      grant_id;
    logic [2**pw-1:0]   busy;
    logic               idle;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, grant_id, busy, idle
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, grant_id, busy, idle
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ
// buffered writeback sources, with a per-register busy scoreboard.
module rf_write_arbiter #(
    parameter int pw   = 3,
    parameter int NREQ = 3,
    parameter int dw   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_write_arbiter_if.slave  bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] pend_vld_q, pend_vld_d;
    logic [pw-1:0]   pend_addr_q [NREQ];
    logic [pw-1:0]   pend_addr_d [NREQ];
    logic [dw-1:0]   pend_data_q [NREQ];
    logic [dw-1:0]   pend_data_d [NREQ];
    logic            wr_en_q, wr_en_d;
    logic [pw-1:0]   wr_addr_q, wr_addr_d;
    logic [dw-1:0]   wr_data_q, wr_data_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] gnt;
    logic [GW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [NREQ-1:0] ready;

    // Grant looks only at buffered entries, so req_valid never feeds the write path.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && pend_vld_q[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = GW'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

    assign ready         = {NREQ{rst_n}} & (~pend_vld_q | gnt);
    assign bus.req_ready = ready;

    always_comb begin
        pend_vld_d  = pend_vld_q & ~gnt;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        wr_en_d     = gnt_any;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_any) begin
            wr_addr_d  = pend_addr_q[gnt_idx];
            wr_data_d  = pend_data_q[gnt_idx];
            grant_id_d = gnt_idx;
            rr_ptr_d   = (gnt_idx == GW'(NREQ - 1)) ? '0 : gnt_idx + GW'(1);
        end
        // A draining buffer may be refilled on the same edge.
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && ready[i]) begin
                pend_vld_d[i]  = 1'b1;
                pend_addr_d[i] = bus.req_addr[i*pw +: pw];
                pend_data_d[i] = bus.req_data[i*dw +: dw];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Buffer payload is qualified by pend_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_addr_q <= pend_addr_d;
        pend_data_q <= pend_data_d;
    end

    always_comb begin
        bus.busy = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pend_vld_q[i]) bus.busy[pend_addr_q[i]] = 1'b1;
        end
        if (wr_en_q) bus.busy[wr_addr_q] = 1'b1;
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.grant_id = grant_id_q;
    assign bus.idle     = ~|pend_vld_q & ~wr_en_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter against a
// transaction-level model of buffers, round-robin grants and the register file.
module tb_rf_write_arbiter;
    localparam int PW   = 3;
    localparam int NR   = 3;
    localparam int DW   = 8;
    localparam int NREG = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.pw(PW), .NREQ(NR), .dw(DW)) bus ();

    rf_write_arbiter #(.pw(PW), .NREQ(NR), .dw(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file written from the DUT's write port
    logic [DW-1:0] rf_dut [NREG];
    always @(posedge clk) if (bus.wr_en) rf_dut[bus.wr_addr] <= bus.wr_data;

    // Reference model state
    bit m_pv [NR];
    int m_pa [NR];
    int m_pd [NR];
    int m_last;
    bit m_wen;
    int m_waddr, m_wdata, m_gid;
    int m_rf [NREG];

    int n_checks = 0;
    int n_fail   = 0;
    logic [NR-1:0] last_ready;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        for (int d = 1; d <= NR; d++) begin
            int j;
            j = (m_last + d) % NR;
            if (m_pv[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_pv[i] = 1'b0;
        m_last  = NR - 1;
        m_wen   = 1'b0;
        m_waddr = 0;
        m_wdata = 0;
        m_gid   = 0;
    endtask

    task automatic check_outputs();
        logic [NREG-1:0] eb;
        bit any;
        eb  = '0;
        any = 1'b0;
        for (int i = 0; i < NR; i++) if (m_pv[i]) begin eb[m_pa[i]] = 1'b1; any = 1'b1; end
        if (m_wen) eb[m_waddr] = 1'b1;
        check_val("wr_en",    32'(bus.wr_en),    32'(m_wen));
        check_val("wr_addr",  32'(bus.wr_addr),  32'(m_waddr));
        check_val("wr_data",  32'(bus.wr_data),  32'(m_wdata));
        check_val("grant_id", 32'(bus.grant_id), 32'(m_gid));
        check_val("busy",     32'(bus.busy),     32'(eb));
        check_val("idle",     32'(bus.idle),     32'(!any && !m_wen));
    endtask

    // One clock: drive inputs after negedge, model the posedge, check at next negedge.
    task automatic cycle(input logic [NR-1:0] v, input logic [NR*PW-1:0] a, input logic [NR*DW-1:0] d);
        int g;
        logic [NR-1:0] rdy;
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        #1;
        g = model_grant();
        for (int i = 0; i < NR; i++) rdy[i] = !m_pv[i] || (g == i);
        last_ready = bus.req_ready;
        check_val("req_ready", 32'(bus.req_ready), 32'(rdy));
        @(posedge clk);
        if (m_wen) m_rf[m_waddr] = m_wdata;
        if (g >= 0) begin
            m_wen = 1'b1; m_waddr = m_pa[g]; m_wdata = m_pd[g];
            m_gid = g; m_last = g; m_pv[g] = 1'b0;
        end else begin
            m_wen = 1'b0;
        end
        for (int i = 0; i < NR; i++) begin
            if (v[i] && rdy[i]) begin
                m_pv[i] = 1'b1;
                m_pa[i] = int'(a[i*PW +: PW]);
                m_pd[i] = int'(d[i*DW +: DW]);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle('0, NR*PW'($urandom), NR*DW'($urandom));
    endtask

    // Reset pulse between edges; called just after a negedge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_wr_en",     32'(bus.wr_en),     32'd0);
        check_val("rst_busy",      32'(bus.busy),      32'd0);
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_val("rst_idle",      32'(bus.idle),      32'd1);
        model_reset();
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    task automatic compare_rf();
        for (int k = 0; k < NREG; k++) check_val($sformatf("rf[%0d]", k), 32'(rf_dut[k]), 32'(m_rf[k]));
    endtask

    initial begin
        for (int k = 0; k < NREG; k++) begin rf_dut[k] = '0; m_rf[k] = 0; end
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        bus.req_valid = '1;
        #1;
        check_val("reset_ready", 32'(bus.req_ready), 32'd0);
        check_outputs();
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset and single write
        cycle(3'b001, {3'd0, 3'd0, 3'd3}, {8'h00, 8'h00, 8'h5A});
        check_val("t1_busy3_accept", 32'(bus.busy[3]), 32'd1);
        check_val("t1_wr_en_accept", 32'(bus.wr_en),   32'd0);
        idle_cycles(1);
        check_val("t1_wr_en",   32'(bus.wr_en),    32'd1);
        check_val("t1_wr_addr", 32'(bus.wr_addr),  32'd3);
        check_val("t1_wr_data", 32'(bus.wr_data),  32'h5A);
        check_val("t1_gid",     32'(bus.grant_id), 32'd0);
        check_val("t1_busy3_w", 32'(bus.busy[3]),  32'd1);
        idle_cycles(1);
        check_val("t1_busy3_end", 32'(bus.busy[3]), 32'd0);
        check_val("t1_idle",      32'(bus.idle),    32'd1);
        check_val("t1_rf3",       32'(rf_dut[3]),   32'h5A);

        // Three-way contention
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cycle(3'b111, {3'd4, 3'd2, 3'd1}, {8'(8'h44 + k), 8'(8'h22 + k), 8'(8'h11 + k)});
            if (k >= 1) begin
                check_val("t2_gid",   32'(bus.grant_id), 32'((k - 1) % 3));
                check_val("t2_wr_en", 32'(bus.wr_en),    32'd1);
            end
        end
        idle_cycles(4);

        // Back-to-back single requester
        for (int k = 0; k < 8; k++) begin
            cycle(3'b010, {3'd0, 3'(k), 3'd0}, {8'h00, 8'(8'h80 + k), 8'h00});
            check_val("t3_ready1", 32'(last_ready[1]), 32'd1);
            if (k >= 1) check_val("t3_wr_addr", 32'(bus.wr_addr), 32'(k - 1));
        end
        idle_cycles(3);
        for (int k = 0; k < 8; k++) check_val("t3_rf", 32'(rf_dut[k]), 32'(8'h80 + k));

        // Same-address conflict
        do_reset();
        cycle(3'b101, {3'd5, 3'd0, 3'd5}, {8'hBB, 8'h00, 8'hAA});
        idle_cycles(1);
        check_val("t4_first",  32'(bus.wr_data), 32'hAA);
        check_val("t4_busy5a", 32'(bus.busy[5]), 32'd1);
        idle_cycles(1);
        check_val("t4_second", 32'(bus.wr_data), 32'hBB);
        check_val("t4_busy5b", 32'(bus.busy[5]), 32'd1);
        idle_cycles(2);
        check_val("t4_rf5", 32'(rf_dut[5]), 32'hBB);

        // Reset mid-operation
        cycle(3'b111, {3'd6, 3'd6, 3'd6}, {8'hE3, 8'hE2, 8'hE1});
        cycle(3'b111, {3'd6, 3'd6, 3'd6}, {8'hE3, 8'hE2, 8'hE4});
        check_val("t5_wr_en_before", 32'(bus.wr_en), 32'd1);
        do_reset();
        idle_cycles(3);
        check_val("t5_rf6", 32'(rf_dut[6]), 32'h86);
        compare_rf();

        // Two requesters valid every cycle
        for (int k = 0; k < 20; k++) cycle(3'b011, NR*PW'($urandom), NR*DW'($urandom));
        idle_cycles(4);
        compare_rf();

        // Randomized traffic with occasional resets
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            cycle(NR'($urandom), NR*PW'($urandom), NR*DW'($urandom));
        end
        idle_cycles(4);
        compare_rf();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
